// File: rtl/qam_pkg.sv
// Shared definitions for the QAM nibble packer: data widths and packer FSM states.
package qam_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned BYTE_W   = 8;

  typedef enum logic [2:0] {
    RD_HI  = 3'd0,
    CAP_HI = 3'd1,
    RD_LO  = 3'd2,
    CAP_LO = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/qam_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones; synchronous clear wins over increment.
module qam_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/qam_nibble_packer.sv
// Pulls nibbles from the demapper two at a time and presents them as bytes with a
// valid/ready handshake; a trailing odd nibble is emitted zero-padded as a partial byte.
module qam_nibble_packer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             dclk,
  input  logic             reset,
  input  logic             available,
  input  logic             complete,
  input  logic [3:0]       nibble_in,
  output logic             read,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             byte_partial,
  output logic [CNT_W-1:0] byte_count,
  output logic             done
);

  import qam_pkg::*;

  state_e              state_q;
  logic [BYTE_W-1:0]   byte_q;
  logic                valid_q;
  logic                partial_q;
  logic                done_q;
  logic                accept;

  // Strobe is decoded from state so the nibble lands in the following CAP_* cycle.
  assign read   = !reset && available && ((state_q == RD_HI) || (state_q == RD_LO));
  assign accept = (state_q == HOLD) && byte_ready;

  always_ff @(posedge dclk) begin
    if (reset) begin
      state_q   <= RD_HI;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      partial_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        RD_HI: begin
          if (available) begin
            state_q <= CAP_HI;
          end else if (complete) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        CAP_HI: begin
          byte_q[BYTE_W-1:NIBBLE_W] <= nibble_in;
          state_q                   <= RD_LO;
        end
        RD_LO: begin
          if (available) begin
            state_q <= CAP_LO;
          end else if (complete) begin
            byte_q[NIBBLE_W-1:0] <= '0;
            partial_q            <= 1'b1;
            valid_q              <= 1'b1;
            state_q              <= HOLD;
          end
        end
        CAP_LO: begin
          byte_q[NIBBLE_W-1:0] <= nibble_in;
          partial_q            <= 1'b0;
          valid_q              <= 1'b1;
          state_q              <= HOLD;
        end
        HOLD: begin
          if (byte_ready) begin
            valid_q <= 1'b0;
            if (partial_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD_HI;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= RD_HI;
        end
      endcase
    end
  end

  qam_sat_counter #(
    .W(CNT_W)
  ) u_byte_cnt (
    .clk_i   (dclk),
    .clr_i   (reset),
    .inc_i   (accept),
    .count_o (byte_count)
  );

  assign byte_out     = byte_q;
  assign byte_valid   = valid_q;
  assign byte_partial = partial_q;
  assign done         = done_q;

endmodule

// File: tb/tb_qam_nibble_packer.sv
// Directed bench for qam_nibble_packer with a simple demapper model feeding nibbles on read.
module tb_qam_nibble_packer;

  logic        dclk = 1'b0;
  logic        reset;
  logic        complete;
  logic        byte_ready;
  logic        avail_en;
  logic        available;
  logic [3:0]  nibble_in = 4'h0;

  logic        read,    read_s;
  logic [7:0]  byte_out, byte_out_s;
  logic        byte_valid, byte_valid_s;
  logic        byte_partial, byte_partial_s;
  logic [15:0] byte_count;
  logic [1:0]  byte_count_s;
  logic        done, done_s;

  logic [3:0]  nib_mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          cyc    = 0;
  int          rd_cnt = 0;
  int          rd_cyc [64];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 dclk = ~dclk;

  assign available = avail_en && (rd_ptr != wr_ptr);

  // Demapper model: data appears the cycle after the read strobe.
  always @(posedge dclk) begin
    cyc <= cyc + 1;
    if (read) begin
      nibble_in      <= nib_mem[rd_ptr];
      rd_ptr         <= rd_ptr + 1;
      rd_cyc[rd_cnt] <= cyc;
      rd_cnt         <= rd_cnt + 1;
    end
  end

  qam_nibble_packer dut (
    .dclk(dclk), .reset(reset), .available(available), .complete(complete),
    .nibble_in(nibble_in), .read(read), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_partial(byte_partial), .byte_count(byte_count),
    .done(done)
  );

  qam_nibble_packer #(.CNT_W(2)) dut_s (
    .dclk(dclk), .reset(reset), .available(available), .complete(complete),
    .nibble_in(nibble_in), .read(read_s), .byte_out(byte_out_s), .byte_valid(byte_valid_s),
    .byte_ready(byte_ready), .byte_partial(byte_partial_s), .byte_count(byte_count_s),
    .done(done_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] n);
    nib_mem[wr_ptr] = n;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!byte_valid && k < 50) begin
      @(negedge dclk);
      k++;
    end
    chk(tag, 32'(byte_valid), 32'd1);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_read"},    32'(read),         32'd0);
    chk({tag, "_valid"},   32'(byte_valid),   32'd0);
    chk({tag, "_partial"}, 32'(byte_partial), 32'd0);
    chk({tag, "_done"},    32'(done),         32'd0);
    chk({tag, "_byte"},    32'(byte_out),     32'h00);
    chk({tag, "_count"},   32'(byte_count),   32'd0);
  endtask

  initial begin
    int base;
    int k;
    reset      = 1'b1;
    complete   = 1'b0;
    byte_ready = 1'b0;
    avail_en   = 1'b0;
    @(negedge dclk);
    @(negedge dclk);
    check_idle_zero("reset");
    chk("reset_small_count", 32'(byte_count_s), 32'd0);
    reset = 1'b0;
    @(negedge dclk);
    chk("post_reset_no_read", 32'(read), 32'd0);

    // Back-to-back single byte A5
    avail_en   = 1'b1;
    byte_ready = 1'b1;
    base = rd_cnt;
    push(4'hA);
    push(4'h5);
    wait_valid("a5_valid");
    chk("a5_byte", 32'(byte_out), 32'hA5);
    chk("a5_partial", 32'(byte_partial), 32'd0);
    chk("a5_read_gap", 32'(rd_cyc[base+1] - rd_cyc[base]), 32'd2);
    @(negedge dclk);
    chk("a5_valid_one_cycle", 32'(byte_valid), 32'd0);
    chk("a5_count", 32'(byte_count), 32'd1);

    // Backpressure: 3C held for 4 cycles
    byte_ready = 1'b0;
    push(4'h3);
    push(4'hC);
    wait_valid("3c_valid");
    for (int i = 0; i < 4; i++) begin
      chk("3c_hold_byte", 32'(byte_out), 32'h3C);
      chk("3c_hold_valid", 32'(byte_valid), 32'd1);
      chk("3c_hold_count", 32'(byte_count), 32'd1);
      chk("3c_hold_read", 32'(read), 32'd0);
      @(negedge dclk);
    end
    chk("3c_still_valid", 32'(byte_valid), 32'd1);
    byte_ready = 1'b1;
    @(negedge dclk);
    chk("3c_accepted", 32'(byte_valid), 32'd0);
    chk("3c_count", 32'(byte_count), 32'd2);
    chk("3c_small_count", 32'(byte_count_s), 32'd2);

    // Three streaming bytes: 5-cycle byte period and 2-bit saturation
    base = rd_cnt;
    push(4'h1); push(4'h1);
    push(4'h2); push(4'h2);
    push(4'h3); push(4'h3);
    wait_valid("s1_valid");
    chk("s1_byte", 32'(byte_out), 32'h11);
    @(negedge dclk);
    wait_valid("s2_valid");
    chk("s2_byte", 32'(byte_out), 32'h22);
    @(negedge dclk);
    wait_valid("s3_valid");
    chk("s3_byte", 32'(byte_out), 32'h33);
    @(negedge dclk);
    chk("stream_period_1", 32'(rd_cyc[base+2] - rd_cyc[base]), 32'd5);
    chk("stream_period_2", 32'(rd_cyc[base+4] - rd_cyc[base+2]), 32'd5);
    chk("stream_count", 32'(byte_count), 32'd5);
    chk("sat_count", 32'(byte_count_s), 32'd3);

    // available has priority over complete
    complete = 1'b1;
    push(4'hF);
    push(4'h0);
    wait_valid("f0_valid");
    chk("f0_byte", 32'(byte_out), 32'hF0);
    chk("f0_partial", 32'(byte_partial), 32'd0);
    chk("f0_not_done", 32'(done), 32'd0);
    @(negedge dclk);
    chk("f0_rdhi_no_read", 32'(read), 32'd0);
    @(negedge dclk);
    chk("f0_done", 32'(done), 32'd1);
    chk("f0_done_valid", 32'(byte_valid), 32'd0);
    chk("f0_count", 32'(byte_count), 32'd6);
    chk("f0_small_sat", 32'(byte_count_s), 32'd3);
    @(negedge dclk);
    @(negedge dclk);
    chk("done_sticky", 32'(done), 32'd1);

    reset    = 1'b1;
    complete = 1'b0;
    @(negedge dclk);
    check_idle_zero("reset2");
    reset = 1'b0;

    // Reset landing in CAP_LO discards the half-built byte
    base = rd_cnt;
    push(4'h8);
    push(4'h9);
    k = 0;
    while (rd_cnt < base + 2 && k < 50) begin
      @(negedge dclk);
      k++;
    end
    chk("mid_reads_seen", 32'(rd_cnt - base), 32'd2);
    reset = 1'b1;
    @(negedge dclk);
    check_idle_zero("mid_reset");
    reset = 1'b0;
    push(4'h4);
    push(4'h4);
    wait_valid("44_valid");
    chk("44_byte", 32'(byte_out), 32'h44);
    @(negedge dclk);
    chk("44_count", 32'(byte_count), 32'd1);

    reset = 1'b1;
    @(negedge dclk);
    reset = 1'b0;

    // Odd nibble count ends with a padded partial byte
    push(4'h1);
    push(4'h2);
    push(4'h7);
    complete = 1'b1;
    wait_valid("12_valid");
    chk("12_byte", 32'(byte_out), 32'h12);
    chk("12_partial", 32'(byte_partial), 32'd0);
    @(negedge dclk);
    wait_valid("70_valid");
    chk("70_byte", 32'(byte_out), 32'h70);
    chk("70_partial", 32'(byte_partial), 32'd1);
    chk("70_not_done", 32'(done), 32'd0);
    @(negedge dclk);
    chk("odd_done", 32'(done), 32'd1);
    chk("odd_valid", 32'(byte_valid), 32'd0);
    chk("odd_count", 32'(byte_count), 32'd2);
    chk("odd_read", 32'(read), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
